dcache_fill_engine: RTL and testbench

- Refill/write-back engine directly downstream of the DCache.
- Consumes the DCache block-request and eviction signals.
- Serialises each 512-bit block into 32-bit beats on a single-word memory bus, and returns assembled refill blocks to the DCache.
- Drives the DCache's data_in_request_i, addr_in_request_i, request_valid_i and evict_i inputs.

---
 rtl/dcache_mem_pkg.sv | 34 +++
 rtl/block_beat_buf.sv | 38 +++
 rtl/dcache_fill_engine.sv | 182 ++++++++++++++++++
 tb/tb_dcache_fill_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_mem_pkg.sv
// Shared types and derived constants for the DCache refill/write-back engine.
// Default geometry is a 512-bit block moved as 32-bit beats.
package dcache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fill_state_t;

  localparam int BLOCK_BITS_DEF = 512;
  localparam int WORD_BITS_DEF  = 32;
  localparam int ADDR_BITS_DEF  = 32;
  localparam int BEATS          = BLOCK_BITS_DEF / WORD_BITS_DEF;
  localparam int OFFSET         = $clog2(BLOCK_BITS_DEF / 8);
  localparam int BEAT_BYTES     = WORD_BITS_DEF / 8;
  localparam int ADDR_MAX       = 64;

  // Clears the byte-offset bits of an address; callers widen/narrow to ADDR_MAX.
  function automatic logic [ADDR_MAX-1:0] block_align(input logic [ADDR_MAX-1:0] addr,
                                                      input int offset);
    logic [ADDR_MAX-1:0] res;
    for (int i = 0; i < ADDR_MAX; i++) begin
      if (i < offset) begin
        res[i] = 1'b0;
      end else begin
        res[i] = addr[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/block_beat_buf.sv
// One-block beat buffer: full-block load for evictions, per-word write for
// refill beats, and a per-word read mux feeding write-back beats.
module block_beat_buf #(
  parameter int BLOCK_BITS = 512,
  parameter int WORD_BITS  = 32,
  parameter int IDX_W      = $clog2(BLOCK_BITS / WORD_BITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [BLOCK_BITS-1:0] load_data_i,
  input  logic                  wr_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [WORD_BITS-1:0]  wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [WORD_BITS-1:0]  rd_data_o,
  output logic [BLOCK_BITS-1:0] data_o
);

  logic [BLOCK_BITS-1:0] buf_r;

  // Block storage; a full load wins over a beat write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_r <= '0;
    end else if (load_i) begin
      buf_r <= load_data_i;
    end else if (wr_i) begin
      buf_r[wr_idx_i*WORD_BITS +: WORD_BITS] <= wr_data_i;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign rd_data_o = buf_r[rd_idx_i*WORD_BITS +: WORD_BITS];
  assign data_o    = buf_r;

endmodule

// File: rtl/dcache_fill_engine.sv
// Refill/write-back engine between the DCache and a single-word memory bus:
// evicted blocks go out as write beats, refills are assembled from read beats.
module dcache_fill_engine
  import dcache_mem_pkg::*;
#(
  parameter int BLOCK_BITS = BLOCK_BITS_DEF,
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  request_i,
  input  logic [ADDR_BITS-1:0]  addr_request_i,
  input  logic                  evict_i,
  input  logic [ADDR_BITS-1:0]  addr_evict_i,
  input  logic [BLOCK_BITS-1:0] data_evict_i,
  output logic                  block_valid_o,
  output logic [ADDR_BITS-1:0]  addr_block_o,
  output logic [BLOCK_BITS-1:0] data_block_o,
  output logic                  evict_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [WORD_BITS-1:0]  mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [WORD_BITS-1:0]  mem_rdata_i
);

  localparam int NBEATS  = BLOCK_BITS / WORD_BITS;
  localparam int NOFFSET = $clog2(BLOCK_BITS / 8);
  localparam int NBYTES  = WORD_BITS / 8;
  localparam int CNT_W   = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  fill_state_t           state_r, next_state_s;
  logic [CNT_W-1:0]      beat_cnt_r, next_cnt_s;
  logic [ADDR_BITS-1:0]  base_r, next_base_s;
  logic                  hold_r, first_wb_r;
  logic [ADDR_BITS-1:0]  blk_addr_r;
  logic [BLOCK_BITS-1:0] blk_data_r;
  logic                  buf_load_s, buf_wr_s, resp_load_s;
  logic [WORD_BITS-1:0]  buf_rd_s;
  logic [BLOCK_BITS-1:0] buf_q_s;
  logic [ADDR_BITS-1:0]  req_align_s, evict_align_s, beat_addr_s;

  assign req_align_s   = ADDR_BITS'(block_align(ADDR_MAX'(addr_request_i), NOFFSET));
  assign evict_align_s = ADDR_BITS'(block_align(ADDR_MAX'(addr_evict_i), NOFFSET));
  assign beat_addr_s   = base_r + ADDR_BITS'(beat_cnt_r) * ADDR_BITS'(NBYTES);

  block_beat_buf #(
    .BLOCK_BITS (BLOCK_BITS),
    .WORD_BITS  (WORD_BITS),
    .IDX_W      (CNT_W)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (buf_load_s),
    .load_data_i (data_evict_i),
    .wr_i        (buf_wr_s),
    .wr_idx_i    (beat_cnt_r),
    .wr_data_i   (mem_rdata_i),
    .rd_idx_i    (beat_cnt_r),
    .rd_data_o   (buf_rd_s),
    .data_o      (buf_q_s)
  );

  // Next-state, beat counter and buffer control.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = beat_cnt_r;
    next_base_s  = base_r;
    buf_load_s   = 1'b0;
    buf_wr_s     = 1'b0;
    resp_load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // hold_r masks the DCache's still-high level request for one cycle
        if (hold_r) begin
          next_state_s = IDLE;
        end else if (evict_i) begin
          next_state_s = WB;
          next_base_s  = evict_align_s;
          buf_load_s   = 1'b1;
        end else if (request_i) begin
          next_state_s = FILL;
          next_base_s  = req_align_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          if (beat_cnt_r == LAST_BEAT) begin
            next_state_s = IDLE;
            next_cnt_s   = '0;
          end else begin
            next_cnt_s = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          next_cnt_s = beat_cnt_r;
        end
      end
      FILL: begin
        if (mem_ack_i) begin
          buf_wr_s = 1'b1;
          if (beat_cnt_r == LAST_BEAT) begin
            next_state_s = RESP;
            next_cnt_s   = '0;
            resp_load_s  = 1'b1;
          end else begin
            next_cnt_s = beat_cnt_r + CNT_W'(1);
          end
        end else begin
          next_cnt_s = beat_cnt_r;
        end
      end
      RESP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = '0;
      end
    endcase
  end

  // State, counter, hold-off and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      base_r     <= '0;
      hold_r     <= 1'b0;
      first_wb_r <= 1'b0;
      blk_addr_r <= '0;
      blk_data_r <= '0;
    end else begin
      state_r    <= next_state_s;
      beat_cnt_r <= next_cnt_s;
      base_r     <= next_base_s;
      hold_r     <= ((state_r == WB) && (next_state_s == IDLE)) || (state_r == RESP);
      first_wb_r <= (state_r == IDLE) && (next_state_s == WB);
      if (resp_load_s) begin
        // the last beat lands in the top word in the same edge as the buffer write
        blk_addr_r <= base_r;
        blk_data_r <= {mem_rdata_i, buf_q_s[BLOCK_BITS-WORD_BITS-1:0]};
      end
    end
  end

  // Memory-side beat outputs, decoded from registered state only.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_r)
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = beat_addr_s;
        mem_wdata_o = buf_rd_s;
      end
      FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = beat_addr_s;
      end
      default: begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
      end
    endcase
  end

  assign block_valid_o = (state_r == RESP);
  assign evict_ack_o   = first_wb_r;
  assign addr_block_o  = blk_addr_r;
  assign data_block_o  = blk_data_r;

endmodule

// File: tb/tb_dcache_fill_engine.sv
// Self-checking bench for dcache_fill_engine: a memory responder records every
// accepted beat and pulse, and each test compares them with expected transfers.
module tb_dcache_fill_engine;

  localparam int NB = 16;

  logic         clk_i = 1'b0;
  logic         rst_i, request_i, evict_i, mem_ack_i;
  logic [31:0]  addr_request_i, addr_evict_i, mem_rdata_i;
  logic [511:0] data_evict_i;
  logic         block_valid_o, evict_ack_o, mem_req_o, mem_we_o;
  logic [31:0]  addr_block_o, mem_addr_o, mem_wdata_o;
  logic [511:0] data_block_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd_salt;

  int           q_beat_cycle[$];
  logic [31:0]  q_beat_addr[$];
  logic [31:0]  q_beat_wdata[$];
  logic         q_beat_we[$];
  int           q_valid_cycle[$];
  logic [31:0]  q_valid_addr[$];
  logic [511:0] q_valid_data[$];
  int           q_ack_cycle[$];
  int           stab_viol;

  dcache_fill_engine dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .request_i(request_i), .addr_request_i(addr_request_i),
    .evict_i(evict_i), .addr_evict_i(addr_evict_i), .data_evict_i(data_evict_i),
    .block_valid_o(block_valid_o), .addr_block_o(addr_block_o), .data_block_o(data_block_o),
    .evict_ack_o(evict_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory responder and recorder for cycles 1..ncyc (cycle 0 = the cycle the
  // request was presented). Memory returns addr ^ rd_salt. req_drop < 0 drops
  // request_i the cycle after block_valid_o is seen.
  task automatic run_cycles(input int ncyc, input int ack_period, input int req_drop);
    logic prev_wait, prev_we, ack;
    logic [31:0] prev_addr, prev_wdata;
    int drop_at;
    q_beat_cycle.delete(); q_beat_addr.delete(); q_beat_wdata.delete(); q_beat_we.delete();
    q_valid_cycle.delete(); q_valid_addr.delete(); q_valid_data.delete(); q_ack_cycle.delete();
    stab_viol = 0;
    prev_wait = 1'b0; prev_we = 1'b0; prev_addr = 32'h0; prev_wdata = 32'h0;
    drop_at = (req_drop < 0) ? 32'h4000_0000 : req_drop;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk_i);
      evict_i = 1'b0;
      if (c >= drop_at) request_i = 1'b0;
      if (prev_wait && (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr ||
                        mem_wdata_o !== prev_wdata || mem_we_o !== prev_we))
        stab_viol++;
      if (evict_ack_o === 1'b1) q_ack_cycle.push_back(c);
      if (block_valid_o === 1'b1) begin
        q_valid_cycle.push_back(c);
        q_valid_addr.push_back(addr_block_o);
        q_valid_data.push_back(data_block_o);
        if (req_drop < 0) drop_at = c + 1;
      end
      ack = ((c % ack_period) == 0);
      mem_ack_i   = ack;
      mem_rdata_i = mem_addr_o ^ rd_salt;
      if (mem_req_o === 1'b1 && ack) begin
        q_beat_cycle.push_back(c);
        q_beat_addr.push_back(mem_addr_o);
        q_beat_wdata.push_back(mem_wdata_o);
        q_beat_we.push_back(mem_we_o);
      end
      prev_wait = (mem_req_o === 1'b1) && !ack;
      prev_we = mem_we_o; prev_addr = mem_addr_o; prev_wdata = mem_wdata_o;
    end
  endtask

  task automatic start_refill(input logic [31:0] a);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    request_i = 1'b1;
    addr_request_i = a;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; request_i = 1'b1; evict_i = 1'b1;
    addr_request_i = 32'h0000_1234; addr_evict_i = 32'h0000_4040; data_evict_i = '1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; rd_salt = 32'h0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({block_valid_o, evict_ack_o, mem_req_o, mem_we_o} !== 4'b0000 ||
        addr_block_o !== 32'h0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 ||
        data_block_o !== 512'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b ack=%b req=%b we=%b addr=%h maddr=%h wdata=%h, required all 0",
               block_valid_o, evict_ack_o, mem_req_o, mem_we_o, addr_block_o, mem_addr_o, mem_wdata_o);
    end
    rst_i = 1'b0; request_i = 1'b0; evict_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (mem_req_o !== 1'b0 || block_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got req=%b valid=%b, required 0 0", mem_req_o, block_valid_o);
    end
  endtask

  task automatic test_refill();
    logic [31:0] a, base;
    logic [511:0] exp_blk;
    int period;
    for (int t = 0; t < 6; t++) begin
      a = (t == 0) ? 32'h0000_1234 : $urandom;
      rd_salt = (t == 0) ? 32'h0 : $urandom;
      period = (t == 0) ? 1 : $urandom_range(1, 2);
      base = a & ~32'h3F;
      for (int k = 0; k < NB; k++) exp_blk[32*k +: 32] = (base + 32'(4*k)) ^ rd_salt;
      start_refill(a);
      run_cycles(NB*period + 8, period, 1);
      n_checks++;
      if (q_beat_addr.size() != NB) begin
        n_fail++;
        $display("FAIL refill_beats t=%0d: got %0d beats, required %0d", t, q_beat_addr.size(), NB);
      end
      for (int k = 0; k < q_beat_addr.size(); k++) begin
        n_checks++;
        if (q_beat_addr[k] !== base + 32'(4*(k % NB)) || q_beat_we[k] !== 1'b0 ||
            (period == 1 && q_beat_cycle[k] != k + 1)) begin
          n_fail++;
          $display("FAIL refill_beat t=%0d k=%0d: got addr=%h we=%b cyc=%0d, required addr=%h we=0",
                   t, k, q_beat_addr[k], q_beat_we[k], q_beat_cycle[k], base + 32'(4*k));
        end
      end
      n_checks++;
      if (q_valid_cycle.size() != 1 || q_ack_cycle.size() != 0) begin
        n_fail++;
        $display("FAIL refill_pulses t=%0d: got %0d valid %0d evict_ack, required 1 0",
                 t, q_valid_cycle.size(), q_ack_cycle.size());
      end else begin
        n_checks++;
        if (q_valid_cycle[0] != NB*period + 1 || q_valid_addr[0] !== base || q_valid_data[0] !== exp_blk) begin
          n_fail++;
          $display("FAIL refill_block t=%0d: got cyc=%0d addr=%h, required cyc=%0d addr=%h (data ok=%b)",
                   t, q_valid_cycle[0], q_valid_addr[0], NB*period + 1, base, q_valid_data[0] === exp_blk);
        end
      end
    end
  endtask

  task automatic test_evict();
    logic [31:0] a, base;
    logic [511:0] d;
    int period;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 32'h0000_4040 : $urandom;
      period = (t == 0) ? 1 : $urandom_range(1, 2);
      base = a & ~32'h3F;
      for (int k = 0; k < NB; k++) d[32*k +: 32] = (t == 0) ? 32'hA5A5_0000 + 32'(k) : $urandom;
      @(negedge clk_i);
      mem_ack_i = 1'b0; evict_i = 1'b1; addr_evict_i = a; data_evict_i = d;
      run_cycles(NB*period + 6, period, 1);
      n_checks++;
      if (q_ack_cycle.size() != 1 || q_valid_cycle.size() != 0 || q_beat_addr.size() != NB) begin
        n_fail++;
        $display("FAIL evict_counts t=%0d: got acks=%0d valids=%0d beats=%0d, required 1 0 %0d",
                 t, q_ack_cycle.size(), q_valid_cycle.size(), q_beat_addr.size(), NB);
      end else begin
        n_checks++;
        if (q_ack_cycle[0] != 1) begin
          n_fail++;
          $display("FAIL evict_ack_cycle t=%0d: got %0d, required 1", t, q_ack_cycle[0]);
        end
      end
      for (int k = 0; k < q_beat_addr.size(); k++) begin
        n_checks++;
        if (q_beat_we[k] !== 1'b1 || q_beat_addr[k] !== base + 32'(4*(k % NB)) ||
            q_beat_wdata[k] !== d[32*(k % NB) +: 32] || (period == 1 && q_beat_cycle[k] != k + 1)) begin
          n_fail++;
          $display("FAIL evict_beat t=%0d k=%0d: got we=%b addr=%h data=%h cyc=%0d, required we=1 addr=%h data=%h",
                   t, k, q_beat_we[k], q_beat_addr[k], q_beat_wdata[k], q_beat_cycle[k],
                   base + 32'(4*k), d[32*(k % NB) +: 32]);
        end
      end
      n_checks++;
      if (mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL evict_idle t=%0d: got mem_req=%b, required 0", t, mem_req_o);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] ra, ea, rbase, ebase;
    logic [511:0] d, exp_blk;
    ra = $urandom; ea = $urandom; rd_salt = $urandom;
    rbase = ra & ~32'h3F; ebase = ea & ~32'h3F;
    for (int k = 0; k < NB; k++) begin
      d[32*k +: 32] = $urandom;
      exp_blk[32*k +: 32] = (rbase + 32'(4*k)) ^ rd_salt;
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    request_i = 1'b1; addr_request_i = ra;
    evict_i = 1'b1; addr_evict_i = ea; data_evict_i = d;
    run_cycles(45, 1, -1);
    n_checks++;
    if (q_beat_addr.size() != 2*NB || q_ack_cycle.size() != 1 || q_valid_cycle.size() != 1) begin
      n_fail++;
      $display("FAIL simul_counts: got beats=%0d acks=%0d valids=%0d, required 32 1 1",
               q_beat_addr.size(), q_ack_cycle.size(), q_valid_cycle.size());
    end else begin
      for (int k = 0; k < 2*NB; k++) begin
        n_checks++;
        if (k < NB) begin
          if (q_beat_we[k] !== 1'b1 || q_beat_addr[k] !== ebase + 32'(4*k) ||
              q_beat_wdata[k] !== d[32*k +: 32] || q_beat_cycle[k] != k + 1) begin
            n_fail++;
            $display("FAIL simul_wr k=%0d: got we=%b addr=%h cyc=%0d, required we=1 addr=%h cyc=%0d",
                     k, q_beat_we[k], q_beat_addr[k], q_beat_cycle[k], ebase + 32'(4*k), k + 1);
          end
        end else begin
          if (q_beat_we[k] !== 1'b0 || q_beat_addr[k] !== rbase + 32'(4*(k-NB)) || q_beat_cycle[k] != k + 3) begin
            n_fail++;
            $display("FAIL simul_rd k=%0d: got we=%b addr=%h cyc=%0d, required we=0 addr=%h cyc=%0d",
                     k, q_beat_we[k], q_beat_addr[k], q_beat_cycle[k], rbase + 32'(4*(k-NB)), k + 3);
          end
        end
      end
      n_checks++;
      if (q_valid_cycle[0] != 35 || q_valid_addr[0] !== rbase || q_valid_data[0] !== exp_blk) begin
        n_fail++;
        $display("FAIL simul_block: got cyc=%0d addr=%h, required cyc=35 addr=%h (data ok=%b)",
                 q_valid_cycle[0], q_valid_addr[0], rbase, q_valid_data[0] === exp_blk);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, base;
    logic [511:0] exp_blk;
    a = $urandom; rd_salt = $urandom; base = a & ~32'h3F;
    for (int k = 0; k < NB; k++) exp_blk[32*k +: 32] = (base + 32'(4*k)) ^ rd_salt;
    start_refill(a);
    run_cycles(3*NB + 6, 3, 1);
    n_checks++;
    if (stab_viol != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable waits, required 0", stab_viol);
    end
    n_checks++;
    if (q_beat_addr.size() != NB || q_valid_cycle.size() != 1) begin
      n_fail++;
      $display("FAIL bp_counts: got beats=%0d valids=%0d, required %0d 1", q_beat_addr.size(), q_valid_cycle.size(), NB);
    end else begin
      for (int k = 0; k < NB; k++) begin
        n_checks++;
        if (q_beat_addr[k] !== base + 32'(4*k) || q_beat_cycle[k] != 3*(k+1)) begin
          n_fail++;
          $display("FAIL bp_beat k=%0d: got addr=%h cyc=%0d, required addr=%h cyc=%0d",
                   k, q_beat_addr[k], q_beat_cycle[k], base + 32'(4*k), 3*(k+1));
        end
      end
      n_checks++;
      if (q_valid_cycle[0] != q_beat_cycle[NB-1] + 1 || q_valid_data[0] !== exp_blk || q_valid_addr[0] !== base) begin
        n_fail++;
        $display("FAIL bp_block: got cyc=%0d addr=%h, required cyc=%0d addr=%h (data ok=%b)",
                 q_valid_cycle[0], q_valid_addr[0], 3*NB + 1, base, q_valid_data[0] === exp_blk);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [511:0] exp_blk;
    rd_salt = $urandom;
    start_refill($urandom);
    run_cycles(5, 1, 1);
    n_checks++;
    if (q_beat_addr.size() != 5 || q_valid_cycle.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_pre: got beats=%0d valids=%0d, required 5 0", q_beat_addr.size(), q_valid_cycle.size());
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if ({block_valid_o, evict_ack_o, mem_req_o, mem_we_o} !== 4'b0000 || mem_addr_o !== 32'h0 ||
        mem_wdata_o !== 32'h0 || addr_block_o !== 32'h0 || data_block_o !== 512'h0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got valid=%b ack=%b req=%b we=%b maddr=%h, required all 0",
               block_valid_o, evict_ack_o, mem_req_o, mem_we_o, mem_addr_o);
    end
    rst_i = 1'b0;
    for (int k = 0; k < NB; k++) exp_blk[32*k +: 32] = (32'h0000_8000 + 32'(4*k)) ^ rd_salt;
    start_refill(32'h0000_8000);
    run_cycles(24, 1, 1);
    n_checks++;
    if (q_beat_addr.size() != NB || q_valid_cycle.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_refill_counts: got beats=%0d valids=%0d, required %0d 1",
               q_beat_addr.size(), q_valid_cycle.size(), NB);
    end else begin
      n_checks++;
      if (q_beat_addr[0] !== 32'h0000_8000 || q_beat_cycle[0] != 1 || q_valid_cycle[0] != 17 ||
          q_valid_addr[0] !== 32'h0000_8000 || q_valid_data[0] !== exp_blk) begin
        n_fail++;
        $display("FAIL midrst_refill: got addr0=%h cyc0=%0d vcyc=%0d vaddr=%h, required 00008000 1 17 00008000 (data ok=%b)",
                 q_beat_addr[0], q_beat_cycle[0], q_valid_cycle[0], q_valid_addr[0], q_valid_data[0] === exp_blk);
      end
    end
  endtask

  task automatic test_hold_request();
    rd_salt = $urandom;
    // request dropped two cycles after RESP: served once
    start_refill($urandom);
    run_cycles(40, 1, 19);
    n_checks++;
    if (q_valid_cycle.size() != 1 || q_beat_addr.size() != NB) begin
      n_fail++;
      $display("FAIL hold_once: got valids=%0d beats=%0d, required 1 %0d", q_valid_cycle.size(), q_beat_addr.size(), NB);
    end
    // still high two cycles after RESP: a second refill follows
    start_refill($urandom);
    run_cycles(45, 1, 20);
    n_checks++;
    if (q_valid_cycle.size() != 2 || q_beat_addr.size() != 2*NB) begin
      n_fail++;
      $display("FAIL hold_twice_counts: got valids=%0d beats=%0d, required 2 %0d",
               q_valid_cycle.size(), q_beat_addr.size(), 2*NB);
    end else begin
      n_checks++;
      if (q_valid_cycle[0] != 17 || q_valid_cycle[1] != 36 || q_beat_cycle[NB] != 20) begin
        n_fail++;
        $display("FAIL hold_twice_timing: got v0=%0d v1=%0d b16=%0d, required 17 36 20",
                 q_valid_cycle[0], q_valid_cycle[1], q_beat_cycle[NB]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_evict();
    test_simultaneous();
    test_backpressure();
    test_reset_mid_fill();
    test_hold_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
